// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared types, constants and helpers for the fetch stage:
//               FSM state encoding, NOP/opcode encodings, PC arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  // Two-bit state encoding; 2'd3 is unreachable and recovers to S_FETCH.
  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DRAIN   = 2'd2,
    S_ILLEGAL = 2'd3
  } fetch_state_e;

  // ADDI x0,x0,0 : the bubble handed to Proc when nothing is ready.
  localparam logic [31:0] C_NOP_INSTR  = 32'h0000_0013;

  // Major opcodes (instruction bits [6:0]).
  localparam logic [6:0]  C_OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0]  C_OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0]  C_OPC_STORE  = 7'b010_0011;
  localparam logic [6:0]  C_OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0]  C_OPC_JAL    = 7'b110_1111;
  localparam logic [6:0]  C_OPC_JALR   = 7'b110_0111;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  // Sequential next PC; wraps modulo 2^32 without any flag.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Bundles the Proc-side control, instruction-memory handshake
//               and instruction output of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;

  // Control from Proc
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // Instruction memory handshake
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Instruction delivered to Proc
  logic [31:0] ir;
  logic [31:0] pc_out;
  logic        ir_valid;

  // The fetch stage itself
  modport master (
    input  stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, ir, pc_out, ir_valid
  );

  // Proc plus instruction memory
  modport slave (
    output stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, ir, pc_out, ir_valid
  );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Holds the fetch PC, runs a single
//               outstanding req/ack transaction to instruction memory,
//               absorbs Proc stalls in a one-entry buffer, applies redirects
//               (draining a wrong-path response if one is in flight) and
//               emits NOP bubbles when no instruction is ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  // Address of the wrong-path request still in flight; the memory sees a
  // stable address until its ack even though fetch_pc is already retargeted.
  logic [31:0]  drain_addr_q, drain_addr_d;
  // One-entry buffer; its contents are meaningful only while in S_HOLD, so
  // leaving S_HOLD is what invalidates it.
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         ir_valid_q, ir_valid_d;

  // Memory request is a pure decode of the state, masked during reset.
  always_comb begin
    bus.imem_req  = ((state_q == S_FETCH) || (state_q == S_DRAIN)) && !reset;
    bus.imem_addr = (state_q == S_DRAIN) ? drain_addr_q : fetch_pc_q;
    bus.ir        = ir_q;
    bus.pc_out    = pc_out_q;
    bus.ir_valid  = ir_valid_q;
  end

  // Next-state logic: redirect outranks ack and stall; otherwise deliver,
  // buffer, hold or bubble depending on state, ack and stall.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    buf_d        = buf_q;
    buf_pc_d     = buf_pc_q;
    ir_d         = ir_q;
    pc_out_d     = pc_out_q;
    ir_valid_d   = ir_valid_q;

    if (bus.redirect_valid) begin
      fetch_pc_d = word_align(bus.redirect_pc);
      ir_d       = NOP_INSTR;
      ir_valid_d = 1'b0;
      case (state_q)
        S_FETCH: begin
          // Ack this cycle means nothing is left in flight: just refetch.
          if (!bus.imem_ack) begin
            state_d      = S_DRAIN;
            drain_addr_d = fetch_pc_q;
          end
        end
        S_HOLD:  state_d = S_FETCH;
        S_DRAIN: state_d = S_DRAIN;
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.imem_ack) begin
            fetch_pc_d = pc_plus4(fetch_pc_q);
            if (bus.stall) begin
              buf_d    = bus.imem_rdata;
              buf_pc_d = fetch_pc_q;
              state_d  = S_HOLD;
            end else begin
              ir_d       = bus.imem_rdata;
              pc_out_d   = fetch_pc_q;
              ir_valid_d = 1'b1;
            end
          end else if (!bus.stall) begin
            ir_d       = NOP_INSTR;
            ir_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!bus.stall) begin
            ir_d       = buf_q;
            pc_out_d   = buf_pc_q;
            ir_valid_d = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_DRAIN: begin
          // Wrong-path data is dropped on the floor.
          if (bus.imem_ack) begin
            state_d = S_FETCH;
          end
          if (!bus.stall) begin
            ir_d       = NOP_INSTR;
            ir_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = S_FETCH;
          if (!bus.stall) begin
            ir_d       = NOP_INSTR;
            ir_valid_d = 1'b0;
          end
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= 32'h0;
      buf_q        <= 32'h0;
      buf_pc_q     <= 32'h0;
      ir_q         <= NOP_INSTR;
      pc_out_q     <= 32'h0;
      ir_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      buf_q        <= buf_d;
      buf_pc_q     <= buf_pc_d;
      ir_q         <= ir_d;
      pc_out_q     <= pc_out_d;
      ir_valid_q   <= ir_valid_d;
    end
  end

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: directed scenarios then
//               randomized stall/redirect/reset/latency traffic, checked
//               against a behavioural model of the fetch pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(C_NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model state
  bit          mem_busy;
  int          mem_lat;
  logic [31:0] mem_busy_addr;
  int          lat_min, lat_max;

  // Behavioural pipeline model
  logic [31:0] m_fetch_pc, m_drain_addr, m_buf, m_buf_pc;
  bit          m_holding, m_draining;
  logic [31:0] m_ir, m_pc;
  logic        m_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0020_0093;
    if (a == 32'h4) return 32'h0040_2023;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  // Advance the model by one clock edge given the inputs seen in that cycle.
  task automatic model_step(input logic r, s, rv, input logic [31:0] rp,
                            input logic ack, input logic [31:0] rdata);
    if (r) begin
      m_fetch_pc = 32'h0; m_holding = 0; m_draining = 0;
      m_ir = C_NOP; m_pc = 32'h0; m_valid = 1'b0;
    end else if (rv) begin
      if (!m_draining && !m_holding && !ack) begin
        m_draining   = 1;
        m_drain_addr = m_fetch_pc;
      end
      m_holding  = 0;
      m_fetch_pc = {rp[31:2], 2'b00};
      m_ir = C_NOP; m_valid = 1'b0;
    end else if (m_holding) begin
      if (!s) begin
        m_ir = m_buf; m_pc = m_buf_pc; m_valid = 1'b1; m_holding = 0;
      end
    end else if (m_draining) begin
      if (ack) m_draining = 0;
      if (!s) begin m_ir = C_NOP; m_valid = 1'b0; end
    end else if (ack) begin
      if (s) begin
        m_buf = rdata; m_buf_pc = m_fetch_pc; m_holding = 1;
      end else begin
        m_ir = rdata; m_pc = m_fetch_pc; m_valid = 1'b1;
      end
      m_fetch_pc = m_fetch_pc + 32'd4;
    end else if (!s) begin
      m_ir = C_NOP; m_valid = 1'b0;
    end
  endtask

  // One clock cycle: drive controls, play memory, check request side,
  // clock the edge, then check the registered outputs.
  task automatic cycle(input logic r, s, rv, input logic [31:0] rp);
    logic        ack;
    logic [31:0] rdata;
    reset = r;
    bus.stall = s;
    bus.redirect_valid = rv;
    bus.redirect_pc = rp;
    #1;
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, (!r && !m_holding)});
    ack = 1'b0;
    rdata = $urandom;
    if (r) begin
      mem_busy = 0;
    end else if (bus.imem_req) begin
      chk("imem_addr", bus.imem_addr, m_draining ? m_drain_addr : m_fetch_pc);
      if (!mem_busy) begin
        mem_busy = 1;
        mem_lat = $urandom_range(lat_min, lat_max);
        mem_busy_addr = bus.imem_addr;
      end else begin
        chk("addr_stable", bus.imem_addr, mem_busy_addr);
      end
      if (mem_lat == 0) begin
        ack = 1'b1;
        rdata = mem_word(mem_busy_addr);
        mem_busy = 0;
      end else begin
        mem_lat--;
      end
    end
    bus.imem_ack = ack;
    bus.imem_rdata = rdata;
    @(posedge clk);
    model_step(r, s, rv, rp, ack, rdata);
    #1;
    chk("ir", bus.ir, m_ir);
    chk("pc_out", bus.pc_out, m_pc);
    chk("ir_valid", {31'b0, bus.ir_valid}, {31'b0, m_valid});
  endtask

  initial begin
    logic r, s, rv;
    logic [31:0] rp;
    reset = 1'b1;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    mem_busy = 0; mem_lat = 0; mem_busy_addr = 32'h0;
    m_fetch_pc = 0; m_drain_addr = 0; m_buf = 0; m_buf_pc = 0;
    m_holding = 0; m_draining = 0; m_ir = C_NOP; m_pc = 0; m_valid = 0;
    lat_min = 0; lat_max = 0;
    @(posedge clk); #1;

    // Reset, then single-cycle memory: back-to-back delivery
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("first_ir", bus.ir, 32'h0020_0093);
    chk("first_pc", bus.pc_out, 32'h0);
    cycle(0, 0, 0, 0);
    chk("second_ir", bus.ir, 32'h0040_2023);
    chk("second_pc", bus.pc_out, 32'h4);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

    // Multi-cycle memory latency: bubbles between instructions
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);

    // Ack under a 4-cycle stall, then release
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // Redirect to an unaligned PC while a request is outstanding
    lat_min = 3; lat_max = 3;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h0000_0FA3);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);

    // Redirect together with stall while holding a buffered word
    lat_min = 0; lat_max = 0;
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 32'h0000_0200);
    chk("hold_redir_ir", bus.ir, C_NOP);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

    // Reset while draining a wrong-path request
    lat_min = 3; lat_max = 3;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h0000_0100);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);

    // PC wrap past the top of the address space
    lat_min = 0; lat_max = 0;
    cycle(0, 0, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

    // Randomized traffic
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0: rp = 32'h0000_0FA3;
        1: rp = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        2: rp = $urandom & 32'h0000_03FF;
        default: rp = $urandom;
      endcase
      cycle(r, s, rv, rp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
